// File: rtl/pc_accumulator_core.sv
// pc_accumulator_core: sequencing core of a 1-bit NAND microprocessor.
// Holds the program counter with its jump/return load path, the 1-bit
// NAND accumulator and the load-next "mode" flag, and decodes the two
// opcode bits of the current instruction into stack/data-memory strobes.
module pc_accumulator_core #(
    parameter int unsigned PC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                preset,
    input  logic [1:0]          op,
    input  logic [PC_WIDTH-1:0] jump_addr,
    input  logic [PC_WIDTH-1:0] ret_addr,
    input  logic                d,
    output logic [PC_WIDTH-1:0] pc,
    output logic                acc,
    output logic                mode,
    output logic                acc_next,
    output logic                push,
    output logic                pop,
    output logic                store
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic                acc_q;
    logic                acc_d;
    logic                mode_q;
    logic                mode_set;

    // Opcode decode: op[1] = store/return, op[0] = branch.
    always_comb begin
        push  = op[0] & ~op[1];
        pop   = op[0] &  op[1];
        store = op[1];
    end

    // Next program counter: a branch loads jump or return target, else count up.
    always_comb begin
        pc_d = pc_q + PC_WIDTH'(1);
        if (op[0]) begin
            pc_d = op[1] ? ret_addr : jump_addr;
        end
    end

    // Next accumulator: a plain load while mode is set, otherwise NAND with d.
    always_comb begin
        acc_d = mode_q ? d : ~(d & acc_q);
    end

    // Any of these holds mode high asynchronously so the next accumulate is a load.
    assign mode_set = reset | preset | op[1] | op[0];

    // Program counter and accumulator, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= '0;
            acc_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            acc_q <= acc_d;
        end
    end

    // Mode flag: level-set while mode_set is high, cleared on the next clock after.
    always_ff @(posedge clk or posedge mode_set) begin
        if (mode_set) begin
            mode_q <= 1'b1;
        end else begin
            mode_q <= 1'b0;
        end
    end

    assign pc       = pc_q;
    assign acc      = acc_q;
    assign mode     = mode_q;
    assign acc_next = acc_d;

endmodule

// File: tb/tb_pc_accumulator_core.sv
// Directed bench for pc_accumulator_core with hand-computed expectations.
module tb_pc_accumulator_core;

    localparam int unsigned PC_WIDTH = 16;

    logic                clk;
    logic                reset;
    logic                preset;
    logic [1:0]          op;
    logic [PC_WIDTH-1:0] jump_addr;
    logic [PC_WIDTH-1:0] ret_addr;
    logic                d;
    logic [PC_WIDTH-1:0] pc;
    logic                acc;
    logic                mode;
    logic                acc_next;
    logic                push;
    logic                pop;
    logic                store;

    int unsigned chk_cnt;
    int unsigned pass_cnt;

    pc_accumulator_core #(
        .PC_WIDTH(PC_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .preset    (preset),
        .op        (op),
        .jump_addr (jump_addr),
        .ret_addr  (ret_addr),
        .d         (d),
        .pc        (pc),
        .acc       (acc),
        .mode      (mode),
        .acc_next  (acc_next),
        .push      (push),
        .pop       (pop),
        .store     (store)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        chk_cnt = chk_cnt + 1;
        if (obs === exp_v) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        chk_cnt   = 0;
        pass_cnt  = 0;
        reset     = 1'b0;
        preset    = 1'b0;
        op        = 2'b00;
        jump_addr = '0;
        ret_addr  = '0;
        d         = 1'b0;

        // Power-on reset
        #2 reset = 1'b1;
        #1;
        check("por_pc",   32'(pc),   32'h0);
        check("por_acc",  32'(acc),  32'h0);
        check("por_mode", 32'(mode), 32'h1);
        step();
        step();
        check("rst_hold_pc", 32'(pc), 32'h0);
        reset = 1'b0;
        #1;

        // Count, then reset mid-count with no clock edge
        for (int i = 0; i < 5; i++) step();
        check("count5_pc",   32'(pc),   32'h5);
        check("count5_mode", 32'(mode), 32'h0);
        reset = 1'b1;
        #1;
        check("async_rst_pc",   32'(pc),   32'h0);
        check("async_rst_acc",  32'(acc),  32'h0);
        check("async_rst_mode", 32'(mode), 32'h1);
        reset = 1'b0;
        #1;
        step();
        check("inc1_pc",   32'(pc),   32'h1);
        check("inc1_mode", 32'(mode), 32'h0);
        step();
        step();
        check("inc3_pc", 32'(pc), 32'h3);

        // Accumulate sequence after reset
        reset = 1'b1;
        #1;
        reset = 1'b0;
        d = 1'b1;
        #1;
        check("acc1_next", 32'(acc_next), 32'h1);
        step();
        check("acc1_acc", 32'(acc), 32'h1);
        d = 1'b1;
        #1;
        check("acc2_next", 32'(acc_next), 32'h0);
        step();
        check("acc2_acc", 32'(acc), 32'h0);
        d = 1'b0;
        #1;
        check("acc3_next", 32'(acc_next), 32'h1);
        step();
        check("acc3_acc", 32'(acc), 32'h1);
        d = 1'b1;
        #1;
        check("acc4_next", 32'(acc_next), 32'h0);
        step();
        check("acc4_acc", 32'(acc), 32'h0);
        check("acc4_pc",  32'(pc),  32'h4);

        // Jump
        op = 2'b01;
        jump_addr = 16'h1234;
        #1;
        check("jmp_push",  32'(push),  32'h1);
        check("jmp_pop",   32'(pop),   32'h0);
        check("jmp_store", 32'(store), 32'h0);
        check("jmp_mode",  32'(mode),  32'h1);
        step();
        check("jmp_pc",      32'(pc),   32'h1234);
        check("jmp_mode_hi", 32'(mode), 32'h1);
        op = 2'b00;
        #1;
        check("jmp_mode_held", 32'(mode), 32'h1);
        step();
        check("after_jmp_pc",   32'(pc),   32'h1235);
        check("after_jmp_mode", 32'(mode), 32'h0);

        // Return, then store-only
        op = 2'b11;
        ret_addr = 16'h0042;
        #1;
        check("ret_pop",   32'(pop),   32'h1);
        check("ret_store", 32'(store), 32'h1);
        check("ret_push",  32'(push),  32'h0);
        step();
        check("ret_pc", 32'(pc), 32'h0042);
        op = 2'b10;
        #1;
        check("st_store", 32'(store), 32'h1);
        check("st_push",  32'(push),  32'h0);
        check("st_pop",   32'(pop),   32'h0);
        check("st_mode",  32'(mode),  32'h1);
        step();
        check("st_pc",      32'(pc),   32'h0043);
        check("st_mode_hi", 32'(mode), 32'h1);
        op = 2'b00;
        step();
        check("post_st_pc",   32'(pc),   32'h0044);
        check("post_st_mode", 32'(mode), 32'h0);

        // Wrap from all-ones
        op = 2'b01;
        jump_addr = 16'hFFFF;
        step();
        check("wrap_jmp_pc", 32'(pc), 32'hFFFF);
        op = 2'b00;
        step();
        check("wrap_pc",   32'(pc),   32'h0000);
        check("wrap_mode", 32'(mode), 32'h0);

        // Preset forces a load
        d = 1'b0;
        step();
        check("pre_setup_acc",  32'(acc),  32'h1);
        check("pre_setup_mode", 32'(mode), 32'h0);
        preset = 1'b1;
        #1;
        check("preset_mode", 32'(mode), 32'h1);
        preset = 1'b0;
        #1;
        check("preset_mode_held", 32'(mode), 32'h1);
        check("preset_next",      32'(acc_next), 32'h0);
        step();
        check("preset_acc",      32'(acc),  32'h0);
        check("preset_mode_clr", 32'(mode), 32'h0);

        // Reset beats a simultaneous jump; preset with reset keeps mode set
        op = 2'b01;
        jump_addr = 16'h5555;
        reset = 1'b1;
        preset = 1'b1;
        step();
        check("rst_vs_jmp_pc", 32'(pc),   32'h0);
        check("rst_preset_mode", 32'(mode), 32'h1);
        reset = 1'b0;
        preset = 1'b0;
        op = 2'b00;
        step();
        check("rel_pc",   32'(pc),   32'h1);
        check("rel_mode", 32'(mode), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pc_accumulator_core.md
Name: pc_accumulator_core

Overview:
Sequencing core of the 1-bit microprocessor. It holds the 16-bit program counter and its jump/return load path, the 1-bit NAND accumulator, and the "mode" (load-next) flag. It decodes the two opcode bits of the current 8-bit instruction. It sits between the 8-bit program memory (which is addressed by pc) and the 1-bit data memory and return stack (driven by d, acc, push, pop, store).

Parameters:
PC_WIDTH, 16, width of program counter, jump_addr and ret_addr.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high; clears pc and acc, sets mode.
preset  input  1  external asynchronous, active-high set of the mode flag.
op  input  2  instruction bits {bit7, bit6}; op[1] = store/return, op[0] = branch.
jump_addr  input  PC_WIDTH  jump target.
ret_addr  input  PC_WIDTH  top-of-stack return address.
d  input  1  operand bit read from data memory.
pc  output  PC_WIDTH  program counter (program memory address).
acc  output  1  accumulator state.
mode  output  1  mode flag; 1 = next accumulate is a plain load.
acc_next  output  1  combinational next-accumulator value.
push  output  1  stack push strobe = op[0] & ~op[1].
pop  output  1  stack pop strobe = op[0] & op[1].
store  output  1  data-memory write enable = op[1].

Behaviour:
- Reset (asynchronous, takes effect immediately, no clock edge needed):
  - pc = 0, acc = 0, mode = 1.
  - Reset has priority over every clocked update.
  - push, pop and store are purely combinational from op and are not affected by reset.
- Program counter, evaluated on each rising clk while reset = 0:
  - If op[0] = 1: pc <= op[1] ? ret_addr : jump_addr.
  - Otherwise: pc <= pc + 1, modulo 2^PC_WIDTH; 0xFFFF wraps to 0x0000.
  - Load has priority over increment. No hold state exists; pc changes every cycle.
- Mode flag:
  - Asynchronous level set when reset | preset | op[1] | op[0] is high. While that set term is high, mode reads 1 and clocks have no effect.
  - Otherwise, mode <= 0 on each rising clk.
  - Effect: the first accumulate after reset, preset, a store, a jump or a return is a load.
- Accumulator:
  - acc_next = mode ? d : ~(d & acc). This is combinational and visible in the same cycle.
  - acc <= acc_next on each rising clk while reset = 0.
- Latency:
  - pc, acc and mode update one clock after their inputs, except for the asynchronous set and clear paths.
  - acc_next, push, pop and store have zero latency.
- Simultaneous events:
  - reset together with a load: reset wins, so pc = 0.
  - preset together with reset: mode = 1, with no conflict.
  - op = 11 (return) asserts pop and store together, and reloads pc from ret_addr.
  - op = 10 (store only) increments pc, asserts store and sets mode.
- All outputs must be X-free after the first reset; there are no initial-value dependencies.

Test Plan:
1. Reset and increment: pulse reset with pc mid-count. Required: pc=0x0000, acc=0 and mode=1 immediately, with no clock edge. Release reset, apply op=00 for 3 clocks. Required: pc=0x0003, and mode=0 after the 1st edge.
2. Accumulate sequence after reset, op=00:
   - d=1 -> acc=1 (load).
   - d=1 -> acc=0 (NAND 1,1).
   - d=0 -> acc=1.
   - d=1 -> acc=0.
   Check acc_next before each edge.
3. Jump: op=01, jump_addr=0x1234. Required: push=1, pop=0, store=0 combinationally; next edge pc=0x1234; mode stays 1 while op=01. Then op=00, next edge mode=0 and pc=0x1235.
4. Return: op=11, ret_addr=0x0042. Required: pop=1, store=1, push=0; next edge pc=0x0042. Store: op=10. Required: pc increments, store=1, mode=1.
5. Wrap: jump to 0xFFFF, then op=00 for one clock. Required: pc=0x0000.
6. External preset: with mode=0, pulse preset between edges. Required: mode=1 immediately. At the next edge with d=0 and acc=1, acc becomes 0 (load, not NAND).
